// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: DMA sequencer states and the fixed register addresses
// used by the DMA arbiter, the address decoder and the PPU register block.
package nes_bus_pkg;

  localparam logic [15:0] DmaRegAddr  = 16'h4014;
  localparam logic [15:0] OamDataAddr = 16'h2004;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } dma_state_e;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA arbiter: a CPU write to the DMA register stalls the CPU, then copies one
// source page into the PPU OAM data port with alternating read/write bus cycles.
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DmaRegAddr,
  parameter logic [15:0] OAM_DATA_ADDR = OamDataAddr,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_r_nw,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  dma_state_e state_q, state_d;
  logic       get_q, get_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      get_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      get_q   <= get_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    get_d   = ~get_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_addr == DMA_REG_ADDR && !cpu_r_nw) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = StHalt;
        end
      end
      StHalt: begin
        // The CPU only honours RDY on reads; reads must land on get=1 slots.
        if (cpu_r_nw) state_d = get_d ? StRead : StAlign;
      end
      StAlign: state_d = StRead;
      StRead: begin
        data_d  = bus_din;
        state_d = StWrite;
      end
      StWrite: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == LastIdx) ? StIdle : StRead;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_r_nw = cpu_r_nw;
    unique case (state_q)
      StAlign: bus_r_nw = 1'b1;
      StRead: begin
        bus_addr = {page_q, idx_q};
        bus_r_nw = 1'b1;
      end
      StWrite: begin
        bus_addr = OAM_DATA_ADDR;
        bus_dout = data_q;
        bus_r_nw = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_din    = bus_din;
  assign cpu_rdy    = (state_q == StIdle);
  assign dma_active = (state_q == StAlign) || (state_q == StRead) || (state_q == StWrite);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: the bench plays the CPU and a read-only memory,
// and checks bus mirroring, transfer contents, stall lengths and mid-transfer reset.
module tb_oam_dma_arbiter;

  logic        clk_ph1;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_r_nw;
  logic [7:0]  bus_din;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  assign bus_din = mem[bus_addr];

  oam_dma_arbiter dut (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_r_nw  (cpu_r_nw),
    .cpu_din   (cpu_din),
    .cpu_rdy   (cpu_rdy),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_r_nw  (bus_r_nw),
    .bus_din   (bus_din),
    .dma_active(dma_active)
  );

  initial clk_ph1 = 1'b0;
  always #5 clk_ph1 = ~clk_ph1;

  // Reference parity: number of edges since reset release, bit 0 is the read-slot flag.
  int unsigned pcnt;
  always @(posedge clk_ph1 or negedge rst) begin
    if (!rst) pcnt <= 0;
    else      pcnt <= pcnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          stall_n, halt_n, dma_n, oam_wr_n;
  logic [7:0]  wq[$];
  logic [15:0] rq[$];
  logic [15:0] prev_addr;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rnw;
    logic [7:0]  exp_din;
    logic        exp_rdy;
    logic        exp_act;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] exp_byte(input logic [7:0] page, input logic [7:0] i);
    case (page)
      8'h02:   return i ^ 8'h5A;
      8'hFF:   return i ^ 8'hC3;
      default: return i ^ page;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    cpu_addr = a;
    cpu_dout = d;
    cpu_r_nw = rnw;
    #1;
    check("cpu_din_eq_bus_din", {24'h0, cpu_din}, {24'h0, bus_din});
    if (!cpu_rdy) stall_n++;
    if (!cpu_rdy && !dma_active) halt_n++;
    if (dma_active) dma_n++;
    if (!bus_r_nw && bus_addr == 16'h2004) oam_wr_n++;
    if (dma_active && !bus_r_nw && bus_addr == 16'h2004) begin
      wq.push_back(bus_dout);
      rq.push_back(prev_addr);
    end
    prev_addr = bus_addr;
  endtask

  task automatic cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    @(negedge clk_ph1);
    drive(a, d, rnw);
  endtask

  task automatic clear_stats();
    stall_n = 0;
    halt_n  = 0;
    dma_n   = 0;
    wq.delete();
    rq.delete();
  endtask

  // Issue the trigger write in a cycle whose read-slot flag equals want.
  task automatic trigger(input logic [7:0] page, input bit want);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_ph1);
      if (pcnt[0] == want) break;
      drive(16'h0000, 8'h00, 1'b1);
    end
    clear_stats();
    drive(16'h4014, page, 1'b0);
  endtask

  task automatic run_reads(input string tag);
    bit done = 0;
    for (int i = 0; i < 700; i++) begin
      cycle(16'h8000, 8'h77, 1'b1);
      if (cpu_rdy) begin
        done = 1;
        break;
      end
    end
    check({tag, "_rdy_returns"}, {31'h0, done}, 32'h1);
    check({tag, "_next_addr"}, {16'h0, bus_addr}, 32'h8000);
    check({tag, "_next_din"}, {24'h0, cpu_din}, 32'h80);
  endtask

  task automatic verify_xfer(input string tag, input logic [7:0] page, input int exp_stall,
                             input int exp_dma, input int exp_halt);
    int bad_d = 0;
    int bad_a = 0;
    check({tag, "_writes"}, wq.size(), 256);
    foreach (wq[i]) begin
      if (wq[i] !== exp_byte(page, i[7:0])) bad_d++;
      if (rq[i] !== {page, i[7:0]}) bad_a++;
    end
    check({tag, "_data_bad"}, bad_d, 0);
    check({tag, "_src_addr_bad"}, bad_a, 0);
    check({tag, "_stall"}, stall_n, exp_stall);
    check({tag, "_dma_cycles"}, dma_n, exp_dma);
    check({tag, "_halt_cycles"}, halt_n, exp_halt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;

    vecs[0] = '{16'h4014, 8'h02, 1'b1, 8'h54, 1'b1, 1'b0};
    vecs[1] = '{16'h4015, 8'h01, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[2] = '{16'h4013, 8'h02, 1'b0, 8'h53, 1'b1, 1'b0};
    vecs[3] = '{16'h0200, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[4] = '{16'h0205, 8'h00, 1'b1, 8'h5F, 1'b1, 1'b0};
    vecs[5] = '{16'h2004, 8'h33, 1'b0, 8'h24, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 8'h11, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[7] = '{16'hFF03, 8'h00, 1'b1, 8'hC0, 1'b1, 1'b0};

    for (int a = 0; a < 65536; a++) begin
      logic [15:0] aa;
      aa = a[15:0];
      mem[a] = exp_byte(aa[15:8], aa[7:0]);
    end
    oam_wr_n  = 0;
    prev_addr = 16'h0;
    clear_stats();

    rst      = 1'b0;
    cpu_addr = 16'h1234;
    cpu_dout = 8'hA7;
    cpu_r_nw = 1'b0;
    #3;
    check("reset_rdy", {31'h0, cpu_rdy}, 32'h1);
    check("reset_active", {31'h0, dma_active}, 32'h0);
    check("reset_addr", {16'h0, bus_addr}, 32'h1234);
    check("reset_dout", {24'h0, bus_dout}, 32'hA7);
    check("reset_rnw", {31'h0, bus_r_nw}, 32'h0);
    repeat (2) @(negedge clk_ph1);
    rst = 1'b1;

    // Idle control vectors: the bus mirrors the CPU and nothing triggers.
    for (int k = 0; k < 8; k++) begin
      cycle(vecs[k].addr, vecs[k].dout, vecs[k].rnw);
      check($sformatf("vec%0d_addr", k), {16'h0, bus_addr}, {16'h0, vecs[k].addr});
      check($sformatf("vec%0d_dout", k), {24'h0, bus_dout}, {24'h0, vecs[k].dout});
      check($sformatf("vec%0d_rnw", k), {31'h0, bus_r_nw}, {31'h0, vecs[k].rnw});
      check($sformatf("vec%0d_din", k), {24'h0, cpu_din}, {24'h0, vecs[k].exp_din});
      check($sformatf("vec%0d_rdy", k), {31'h0, cpu_rdy}, {31'h0, vecs[k].exp_rdy});
      check($sformatf("vec%0d_active", k), {31'h0, dma_active}, {31'h0, vecs[k].exp_act});
    end

    // Trigger on a read slot: no ALIGN, 513-cycle stall.
    trigger(8'h02, 1'b1);
    run_reads("odd");
    verify_xfer("odd", 8'h02, 513, 512, 1);

    // Trigger on a write slot: ALIGN inserted, 514-cycle stall.
    trigger(8'h02, 1'b0);
    run_reads("even");
    verify_xfer("even", 8'h02, 514, 513, 1);

    // Trigger followed by two stack pushes: both pass through while halted.
    trigger(8'h02, 1'b1);
    cycle(16'h01FD, 8'h12, 1'b0);
    check("jsr1_addr", {16'h0, bus_addr}, 32'h01FD);
    check("jsr1_dout", {24'h0, bus_dout}, 32'h12);
    check("jsr1_rnw", {31'h0, bus_r_nw}, 32'h0);
    check("jsr1_rdy", {31'h0, cpu_rdy}, 32'h0);
    cycle(16'h01FC, 8'h34, 1'b0);
    check("jsr2_addr", {16'h0, bus_addr}, 32'h01FC);
    check("jsr2_dout", {24'h0, bus_dout}, 32'h34);
    check("jsr2_rnw", {31'h0, bus_r_nw}, 32'h0);
    check("jsr2_active", {31'h0, dma_active}, 32'h0);
    run_reads("jsr");
    verify_xfer("jsr", 8'h02, 515, 512, 3);

    // Top page: source runs to $FFFF without wrapping.
    trigger(8'hFF, 1'b0);
    run_reads("pageff");
    verify_xfer("pageff", 8'hFF, 514, 513, 1);

    // Reset in the READ cycle for idx $40 abandons the transfer at once.
    trigger(8'h02, 1'b1);
    for (int i = 0; i < 600; i++) begin
      cycle(16'h8000, 8'h77, 1'b1);
      if (wq.size() == 64) break;
    end
    check("rst_writes_before", wq.size(), 64);
    cycle(16'h8000, 8'h77, 1'b1);
    check("rst_pre_addr", {16'h0, bus_addr}, 32'h0240);
    check("rst_pre_active", {31'h0, dma_active}, 32'h1);
    rst = 1'b0;
    #1;
    check("rst_mid_active", {31'h0, dma_active}, 32'h0);
    check("rst_mid_rdy", {31'h0, cpu_rdy}, 32'h1);
    check("rst_mid_addr", {16'h0, bus_addr}, 32'h8000);
    check("rst_mid_dout", {24'h0, bus_dout}, 32'h77);
    check("rst_mid_rnw", {31'h0, bus_r_nw}, 32'h1);
    cpu_addr = 16'h1234;
    cpu_dout = 8'h9A;
    cpu_r_nw = 1'b0;
    #1;
    check("rst_mid_waddr", {16'h0, bus_addr}, 32'h1234);
    check("rst_mid_wdout", {24'h0, bus_dout}, 32'h9A);
    check("rst_mid_wrnw", {31'h0, bus_r_nw}, 32'h0);
    repeat (2) @(negedge clk_ph1);
    rst = 1'b1;
    clear_stats();
    wr_before = oam_wr_n;
    for (int i = 0; i < 40; i++) cycle(16'h8000, 8'h77, 1'b1);
    check("rst_after_oam_writes", oam_wr_n - wr_before, 0);
    check("rst_after_dma", dma_n, 0);
    check("rst_after_stall", stall_n, 0);

    // A fresh trigger after the abandoned one runs a full transfer.
    trigger(8'h02, 1'b1);
    run_reads("retrig");
    verify_xfer("retrig", 8'h02, 513, 512, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
